scm_arb: RTL and testbench

SCM_ARB -- requirements
Module: scm_arb

---
 rtl/scm_pkg.sv | 11 +
 rtl/rr_arb2.sv | 35 +++
 rtl/scm_arb.sv | 117 +++++++++++
 tb/tb_scm_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scm_pkg.sv
// Shared sizing and FSM state for the SCM write/read arbiter.
package scm_pkg;
  localparam int SCM_ADDR_WIDTH = 6;
  localparam int SCM_DATA_WIDTH = 64;
  localparam int SCM_NUM_ROWS   = 2**SCM_ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } scm_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req_vld, gated by gnt_en.
// The priority pointer only moves to the other requester when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gnt_en,
  input  logic [1:0] req_vld,
  output logic [1:0] cand,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  always_comb begin
    cand = 2'b00;
    if (req_vld[ptr_q]) begin
      cand[ptr_q] = 1'b1;
    end else if (req_vld[~ptr_q]) begin
      cand[~ptr_q] = 1'b1;
    end
    gnt   = gnt_en ? cand : 2'b00;
    ptr_d = ptr_q;
    // Granting requester 0 hands priority to 1, and vice versa.
    if (|gnt) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/scm_arb.sv
// SCM front end: clears every row after reset, then round-robins two writers and two readers.
// Read data returns one cycle after grant; READY is combinational; a same-address read yields to the write.
module scm_arb
  import scm_pkg::*;
#(
  parameter int ADDR_WIDTH = SCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SCM_DATA_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [1:0]              REQ_WVALID,
  output logic [1:0]              REQ_WREADY,
  input  logic [2*ADDR_WIDTH-1:0] REQ_WADDR,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [1:0]              REQ_RVALID,
  output logic [1:0]              REQ_RREADY,
  input  logic [2*ADDR_WIDTH-1:0] REQ_RADDR,
  output logic [1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_DATA,
  output logic                    SCM_WE,
  output logic                    SCM_RE,
  output logic                    SCM_SE,
  output logic [ADDR_WIDTH-1:0]   SCM_WADDR,
  output logic [ADDR_WIDTH-1:0]   SCM_RADDR,
  output logic [DATA_WIDTH-1:0]   SCM_DIN,
  input  logic [DATA_WIDTH-1:0]   SCM_DOUT,
  output logic                    INIT_DONE
);
  localparam int NUM_ROWS = 2**ADDR_WIDTH;

  scm_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [1:0]              rsp_vld_q, rsp_vld_d;
  logic                    run;
  logic                    collide;
  logic                    scm_we;
  logic [1:0]              wcand, wgnt, rcand, rgnt;
  logic [ADDR_WIDTH-1:0]   waddr_sel, raddr_sel, scm_waddr;
  logic [DATA_WIDTH-1:0]   wdata_sel, scm_din;

  assign run       = (state_q == ST_RUN);
  assign waddr_sel = wcand[1] ? REQ_WADDR[ADDR_WIDTH +: ADDR_WIDTH] : REQ_WADDR[0 +: ADDR_WIDTH];
  assign wdata_sel = wcand[1] ? REQ_WDATA[DATA_WIDTH +: DATA_WIDTH] : REQ_WDATA[0 +: DATA_WIDTH];
  assign raddr_sel = rcand[1] ? REQ_RADDR[ADDR_WIDTH +: ADDR_WIDTH] : REQ_RADDR[0 +: ADDR_WIDTH];

  // The read is held off (pointer frozen) so its retry sees the freshly written word.
  assign collide = (|wgnt) & (|rcand) & (waddr_sel == raddr_sel);

  rr_arb2 u_wr_arb (
    .clk     (CLK),
    .rst_n   (RST_N),
    .gnt_en  (run),
    .req_vld (REQ_WVALID),
    .cand    (wcand),
    .gnt     (wgnt)
  );

  rr_arb2 u_rd_arb (
    .clk     (CLK),
    .rst_n   (RST_N),
    .gnt_en  (run & ~collide),
    .req_vld (REQ_RVALID),
    .cand    (rcand),
    .gnt     (rgnt)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    scm_we     = 1'b0;
    scm_waddr  = waddr_sel;
    scm_din    = wdata_sel;
    rsp_vld_d  = rgnt;
    case (state_q)
      ST_INIT: begin
        scm_we     = 1'b1;
        scm_waddr  = init_cnt_q;
        scm_din    = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_WIDTH'(NUM_ROWS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        scm_we = |wgnt;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      rsp_vld_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rsp_vld_q  <= rsp_vld_d;
    end
  end

  // Reset state is INIT, which would otherwise assert the sweep write while RST_N is low.
  assign SCM_WE     = scm_we & RST_N;
  assign SCM_WADDR  = scm_waddr;
  assign SCM_DIN    = scm_din;
  assign SCM_RE     = |rgnt;
  assign SCM_RADDR  = raddr_sel;
  assign SCM_SE     = 1'b0;
  assign REQ_WREADY = wgnt;
  assign REQ_RREADY = rgnt;
  assign RSP_VALID  = rsp_vld_q;
  assign RSP_DATA   = SCM_DOUT;
  assign INIT_DONE  = run;
endmodule

// File: tb/tb_scm_arb.sv
// Randomized self-checking bench for scm_arb against a round-robin/scoreboard reference model.
module tb_scm_arb;
  localparam int AW   = 6;
  localparam int DW   = 64;
  localparam int ROWS = 1 << AW;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [1:0]    wvld, rvld;
  logic [AW-1:0] wa [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] wd [2];

  logic [2*AW-1:0] req_waddr, req_raddr;
  logic [2*DW-1:0] req_wdata;
  assign req_waddr = {wa[1], wa[0]};
  assign req_raddr = {ra[1], ra[0]};
  assign req_wdata = {wd[1], wd[0]};

  logic [1:0]    REQ_WREADY, REQ_RREADY, RSP_VALID;
  logic [DW-1:0] RSP_DATA, SCM_DIN, SCM_DOUT;
  logic          SCM_WE, SCM_RE, SCM_SE, INIT_DONE;
  logic [AW-1:0] SCM_WADDR, SCM_RADDR;

  scm_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ_WVALID (wvld),
    .REQ_WREADY (REQ_WREADY),
    .REQ_WADDR  (req_waddr),
    .REQ_WDATA  (req_wdata),
    .REQ_RVALID (rvld),
    .REQ_RREADY (REQ_RREADY),
    .REQ_RADDR  (req_raddr),
    .RSP_VALID  (RSP_VALID),
    .RSP_DATA   (RSP_DATA),
    .SCM_WE     (SCM_WE),
    .SCM_RE     (SCM_RE),
    .SCM_SE     (SCM_SE),
    .SCM_WADDR  (SCM_WADDR),
    .SCM_RADDR  (SCM_RADDR),
    .SCM_DIN    (SCM_DIN),
    .SCM_DOUT   (SCM_DOUT),
    .INIT_DONE  (INIT_DONE)
  );

  // Behavioural SCM macro: synchronous write, registered read.
  logic [DW-1:0] scm_mem [ROWS];
  logic [DW-1:0] scm_dout_q;
  assign SCM_DOUT = scm_dout_q;
  always @(posedge CLK) begin
    if (SCM_WE) scm_mem[SCM_WADDR] <= SCM_DIN;
    if (SCM_RE) scm_dout_q <= scm_mem[SCM_RADDR];
  end

  // Reference model state.
  int            wptr, rptr, last_wg, last_rg;
  logic [DW-1:0] sb [ROWS];
  logic [1:0]    exp_rsp;
  logic [DW-1:0] exp_dat;
  logic [1:0]    obs_wrdy, obs_rrdy, obs_rsp;
  logic [DW-1:0] obs_dat;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v, input int p);
    if (v[p]) return p;
    if (v[1-p]) return 1 - p;
    return -1;
  endfunction

  function automatic void model_reset();
    wptr = 0;
    rptr = 0;
    exp_rsp = 2'b00;
    exp_dat = '0;
    last_wg = -1;
    last_rg = -1;
    for (int a = 0; a < ROWS; a++) sb[a] = '0;
  endfunction

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    int wg, rc, rg;
    logic [1:0] ew, er;
    #1;
    wg = pick(wvld, wptr);
    rc = pick(rvld, rptr);
    rg = rc;
    if (wg >= 0 && rc >= 0 && wa[wg] == ra[rc]) rg = -1;
    ew = 2'b00;
    er = 2'b00;
    if (wg >= 0) ew[wg] = 1'b1;
    if (rg >= 0) er[rg] = 1'b1;
    obs_wrdy = REQ_WREADY;
    obs_rrdy = REQ_RREADY;
    obs_rsp  = RSP_VALID;
    obs_dat  = RSP_DATA;
    chk("init_done", INIT_DONE, 1);
    chk("wready", REQ_WREADY, ew);
    chk("rready", REQ_RREADY, er);
    chk("scm_we", SCM_WE, wg >= 0);
    if (wg >= 0) begin
      chk("scm_waddr", SCM_WADDR, wa[wg]);
      chk("scm_din", SCM_DIN, wd[wg]);
    end
    chk("scm_re", SCM_RE, rg >= 0);
    if (rg >= 0) chk("scm_raddr", SCM_RADDR, ra[rg]);
    chk("rsp_valid", RSP_VALID, exp_rsp);
    if (exp_rsp != 2'b00) chk("rsp_data", RSP_DATA, exp_dat);
    chk("scm_se", SCM_SE, 0);
    exp_rsp = er;
    if (rg >= 0) begin
      exp_dat = sb[ra[rg]];
      rptr = 1 - rg;
    end
    if (wg >= 0) begin
      sb[wa[wg]] = wd[wg];
      wptr = 1 - wg;
    end
    last_wg = wg;
    last_rg = rg;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Starts at a falling edge right after reset release; returns early at row stop_at.
  task automatic sweep_check(input int stop_at);
    logic [AW-1:0] row;
    wvld = 2'b11;
    rvld = 2'b11;
    for (int i = 0; i < ROWS; i++) begin
      row = AW'(i);
      #1;
      chk("sweep_we", SCM_WE, 1);
      chk("sweep_waddr", SCM_WADDR, row);
      chk("sweep_din", SCM_DIN, 0);
      chk("sweep_rdy", {REQ_WREADY, REQ_RREADY}, 0);
      chk("sweep_done", INIT_DONE, 0);
      if (i == stop_at) return;
      @(posedge CLK);
      @(negedge CLK);
    end
    wvld = 2'b00;
    rvld = 2'b00;
    model_reset();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_we"}, SCM_WE, 0);
    chk({tag, "_re"}, SCM_RE, 0);
    chk({tag, "_done"}, INIT_DONE, 0);
    chk({tag, "_rsp"}, RSP_VALID, 0);
    chk({tag, "_rdy"}, {REQ_WREADY, REQ_RREADY}, 0);
  endtask

  logic [1:0] wseq [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b1;
    wvld = 2'b11;
    rvld = 2'b11;
    wa[0] = 1; wa[1] = 2; ra[0] = 3; ra[1] = 4;
    wd[0] = '0; wd[1] = '0;
    model_reset();
    #2 RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 reset_checks("rst");
    @(negedge CLK);
    RST_N = 1'b1;
    sweep_check(ROWS);

    // Post-init read of address 5 by requester 1.
    ra[1] = 5; rvld = 2'b10;
    step();
    chk("rd5_rready", obs_rrdy, 2'b10);
    rvld = 2'b00;
    step();
    chk("rd5_rsp", obs_rsp, 2'b10);
    chk("rd5_data", obs_dat, 0);

    // Both writers held valid for four cycles.
    wseq = '{2'b01, 2'b10, 2'b01, 2'b10};
    wa[0] = 1; wa[1] = 2; wvld = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wd[0] = 64'h1000 + DW'(k);
      wd[1] = 64'h2000 + DW'(k);
      step();
      chk($sformatf("wseq%0d", k), obs_wrdy, wseq[k]);
    end
    wvld = 2'b00;
    ra[0] = 1; rvld = 2'b01;
    step();
    ra[1] = 2; rvld = 2'b10;
    step();
    chk("rb1_rsp", obs_rsp, 2'b01);
    chk("rb1_data", obs_dat, 64'h1002);
    rvld = 2'b00;
    step();
    chk("rb2_rsp", obs_rsp, 2'b10);
    chk("rb2_data", obs_dat, 64'h2003);

    // Same-address write and read in one cycle.
    wa[0] = 9; wd[0] = 64'hDEADBEEF; wvld = 2'b01;
    ra[1] = 9; rvld = 2'b10;
    step();
    chk("col_wready", obs_wrdy, 2'b01);
    chk("col_rready", obs_rrdy, 2'b00);
    wvld = 2'b00;
    step();
    chk("col_retry", obs_rrdy, 2'b10);
    rvld = 2'b00;
    step();
    chk("col_rsp", obs_rsp, 2'b10);
    chk("col_data", obs_dat, 64'hDEADBEEF);

    // Random soak; a pending request keeps its address/data until granted.
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(wvld[r] && last_wg != r)) begin
          wvld[r] = 1'($urandom_range(0, 1));
          wa[r]   = AW'($urandom_range(0, 15));
          wd[r]   = {$urandom, $urandom};
        end
        if (!(rvld[r] && last_rg != r)) begin
          rvld[r] = 1'($urandom_range(0, 1));
          ra[r]   = AW'($urandom_range(0, 15));
        end
      end
      step();
    end
    wvld = 2'b00;
    rvld = 2'b00;
    step();

    // A read granted just before reset must not respond.
    ra[0] = 3; rvld = 2'b01;
    step();
    rvld = 2'b00;
    RST_N = 1'b0;
    #1 reset_checks("rdrst");
    @(negedge CLK);
    RST_N = 1'b1;

    // Reset in the middle of the clear sweep.
    sweep_check(30);
    #1 RST_N = 1'b0;
    #1 reset_checks("midrst");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    sweep_check(ROWS);
    ra[0] = 9; rvld = 2'b01;
    step();
    rvld = 2'b00;
    step();
    chk("after_rst_rsp", obs_rsp, 2'b01);
    chk("after_rst_data", obs_dat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
